// File: rtl/axi_sram_slave.sv
// AXI memory responder backed by an internal byte-maskable word array.
// Read (AR/R) and write (AW/W/B) channels run independent FSMs; FIXED/INCR/WRAP bursts.
module axi_sram_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(32'h8000_0000),
  parameter int unsigned RD_LAT     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  input  logic [1:0]              arburst,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  output logic                    rlast,
  input  logic                    rready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  input  logic [1:0]              awburst,
  input  logic [7:0]              awlen,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned BSH    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned WAIT_W = $clog2(RD_LAT + 1);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * STRB_W);

  localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a - BASE_ADDR) < MEM_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> BSH);
  endfunction

  function automatic logic burst_bad(input logic [1:0] b, input logic [7:0] l, input logic [2:0] s);
    return (b == 2'b11) || (s > 3'(BSH)) ||
           ((b == 2'b10) && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15));
  endfunction

  // WRAP keeps the upper bits and wraps the low bits inside a (len+1)<<size container.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
      input logic [1:0] b, input logic [2:0] s, input logic [7:0] l);
    logic [ADDR_WIDTH-1:0] step, mask;
    step = ADDR_WIDTH'(1) << s;
    mask = ((ADDR_WIDTH'(l) + ADDR_WIDTH'(1)) << s) - ADDR_WIDTH'(1);
    case (b)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~mask) | ((a + step) & mask);
      default: next_addr = a + step;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [1:0]            r_state, r_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, r_addr_nxt, r_ld_addr;
  logic [1:0]            r_burst, r_burst_nxt;
  logic [2:0]            r_size, r_size_nxt;
  logic [7:0]            r_len, r_len_nxt, r_cnt, r_cnt_nxt;
  logic [WAIT_W-1:0]     r_wait, r_wait_nxt;
  logic                  r_err, r_err_nxt, r_ld_err, r_ld_ok;
  logic [DATA_WIDTH-1:0] r_ld_data, rdata_nxt;
  logic [1:0]            r_ld_resp, rresp_nxt;
  logic                  arready_nxt, rvalid_nxt, rlast_nxt;

  logic [1:0]            w_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_addr, w_addr_nxt;
  logic [1:0]            w_burst, w_burst_nxt;
  logic [7:0]            w_len, w_len_nxt;
  logic [8:0]            w_beat, w_beat_nxt;
  logic                  w_err, w_err_nxt, w_bad, w_bad_nxt;
  logic                  w_hs, w_beat_ok, mem_we;
  logic                  awready_nxt, wready_nxt, bvalid_nxt;
  logic [1:0]            bresp_nxt;

  // Address whose word is loaded into rdata on the coming edge.
  always_comb begin
    r_ld_addr = r_addr;
    r_ld_err  = r_err;
    case (r_state)
      R_IDLE: begin
        r_ld_addr = araddr;
        r_ld_err  = burst_bad(arburst, arlen, arsize) || !in_range(araddr);
      end
      R_DATA:  r_ld_addr = next_addr(r_addr, r_burst, r_size, r_len);
      default: r_ld_addr = r_addr;
    endcase
  end

  assign r_ld_ok   = !r_ld_err && in_range(r_ld_addr);
  assign r_ld_data = r_ld_ok ? mem[word_idx(r_ld_addr)] : '0;
  assign r_ld_resp = r_ld_ok ? RESP_OKAY : RESP_SLVERR;

  always_comb begin
    r_state_nxt = r_state;
    r_addr_nxt  = r_addr;
    r_burst_nxt = r_burst;
    r_size_nxt  = r_size;
    r_len_nxt   = r_len;
    r_cnt_nxt   = r_cnt;
    r_wait_nxt  = r_wait;
    r_err_nxt   = r_err;
    arready_nxt = arready;
    rvalid_nxt  = rvalid;
    rlast_nxt   = rlast;
    rdata_nxt   = rdata;
    rresp_nxt   = rresp;
    case (r_state)
      R_IDLE: if (arvalid && arready) begin
        r_addr_nxt  = araddr;
        r_burst_nxt = arburst;
        r_size_nxt  = arsize;
        r_len_nxt   = arlen;
        r_cnt_nxt   = arlen;
        r_err_nxt   = r_ld_err;
        r_wait_nxt  = WAIT_W'(RD_LAT - 1);
        arready_nxt = 1'b0;
        if (RD_LAT <= 1) begin
          r_state_nxt = R_DATA;
          rvalid_nxt  = 1'b1;
          rlast_nxt   = (arlen == 8'd0);
          rdata_nxt   = r_ld_data;
          rresp_nxt   = r_ld_resp;
        end else begin
          r_state_nxt = R_WAIT;
        end
      end
      R_WAIT: begin
        r_wait_nxt = r_wait - WAIT_W'(1);
        if (r_wait <= WAIT_W'(1)) begin
          r_state_nxt = R_DATA;
          rvalid_nxt  = 1'b1;
          rlast_nxt   = (r_cnt == 8'd0);
          rdata_nxt   = r_ld_data;
          rresp_nxt   = r_ld_resp;
        end
      end
      R_DATA: if (rready) begin
        if (r_cnt == 8'd0) begin
          r_state_nxt = R_IDLE;
          arready_nxt = 1'b1;
          rvalid_nxt  = 1'b0;
          rlast_nxt   = 1'b0;
          rdata_nxt   = '0;
          rresp_nxt   = RESP_OKAY;
        end else begin
          r_addr_nxt = r_ld_addr;
          r_cnt_nxt  = r_cnt - 8'd1;
          rlast_nxt  = (r_cnt == 8'd1);
          rdata_nxt  = r_ld_data;
          rresp_nxt  = r_ld_resp;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Beats are dropped on a burst-level error, past the top of memory, or past awlen.
  assign w_hs      = (w_state == W_DATA) && wvalid && wready;
  assign w_beat_ok = !w_err && in_range(w_addr) && (w_beat <= {1'b0, w_len});
  assign mem_we    = w_hs && w_beat_ok && !rst;

  always_comb begin
    w_state_nxt = w_state;
    w_addr_nxt  = w_addr;
    w_burst_nxt = w_burst;
    w_len_nxt   = w_len;
    w_beat_nxt  = w_beat;
    w_err_nxt   = w_err;
    w_bad_nxt   = w_bad;
    awready_nxt = awready;
    wready_nxt  = wready;
    bvalid_nxt  = bvalid;
    bresp_nxt   = bresp;
    case (w_state)
      W_IDLE: if (awvalid && awready) begin
        w_addr_nxt  = awaddr;
        w_burst_nxt = awburst;
        w_len_nxt   = awlen;
        w_beat_nxt  = '0;
        w_err_nxt   = burst_bad(awburst, awlen, 3'(BSH)) || !in_range(awaddr);
        w_bad_nxt   = 1'b0;
        awready_nxt = 1'b0;
        wready_nxt  = 1'b1;
        w_state_nxt = W_DATA;
      end
      W_DATA: if (w_hs) begin
        w_addr_nxt = next_addr(w_addr, w_burst, 3'(BSH), w_len);
        if (w_beat != 9'h1FF) w_beat_nxt = w_beat + 9'd1;
        w_bad_nxt = w_bad || !w_beat_ok;
        if (wlast) begin
          w_state_nxt = W_RESP;
          wready_nxt  = 1'b0;
          bvalid_nxt  = 1'b1;
          bresp_nxt   = (w_bad || !w_beat_ok || (w_beat != {1'b0, w_len})) ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: if (bready) begin
        w_state_nxt = W_IDLE;
        bvalid_nxt  = 1'b0;
        bresp_nxt   = RESP_OKAY;
        awready_nxt = 1'b1;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_burst <= '0;
      r_size  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_err   <= 1'b0;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_burst <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_err   <= 1'b0;
      w_bad   <= 1'b0;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= '0;
    end else begin
      r_state <= r_state_nxt;
      r_addr  <= r_addr_nxt;
      r_burst <= r_burst_nxt;
      r_size  <= r_size_nxt;
      r_len   <= r_len_nxt;
      r_cnt   <= r_cnt_nxt;
      r_wait  <= r_wait_nxt;
      r_err   <= r_err_nxt;
      arready <= arready_nxt;
      rvalid  <= rvalid_nxt;
      rlast   <= rlast_nxt;
      rdata   <= rdata_nxt;
      rresp   <= rresp_nxt;
      w_state <= w_state_nxt;
      w_addr  <= w_addr_nxt;
      w_burst <= w_burst_nxt;
      w_len   <= w_len_nxt;
      w_beat  <= w_beat_nxt;
      w_err   <= w_err_nxt;
      w_bad   <= w_bad_nxt;
      awready <= awready_nxt;
      wready  <= wready_nxt;
      bvalid  <= bvalid_nxt;
      bresp   <= bresp_nxt;
    end
  end

  // Array has no reset so contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed testbench for axi_sram_slave: reads, writes, bursts, errors and reset.
module tb_axi_sram_slave;

  logic        clk, rst;
  logic [31:0] araddr, awaddr;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic [1:0]  arburst, rresp, awburst, bresp;
  logic [7:0]  arlen, awlen, wstrb;
  logic [2:0]  arsize;
  logic [63:0] rdata, wdata;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] wbeats [16];
  logic [7:0]  wstrbs [16];
  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  int          rd_unstable, rd_gaps;

  localparam logic [63:0] WV0 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] WV1 = 64'h1111_1111_0000_0001;
  localparam logic [63:0] WV2 = 64'h2222_2222_0000_0002;
  localparam logic [63:0] WV3 = 64'h3333_3333_0000_0003;
  localparam logic [63:0] WV4 = 64'h4444_4444_0000_0004;
  localparam logic [63:0] WTOP = 64'hDEAD_BEEF_CAFE_F00D;

  axi_sram_slave dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arburst(arburst), .arlen(arlen), .arsize(arsize),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awburst(awburst), .awlen(awlen), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one write burst from wbeats/wstrbs; reports response, latency and bvalid hold.
  task automatic do_write(input logic [31:0] a, input logic [1:0] b, input logic [7:0] l,
                          input int nbeats, input int last_at, input int bdelay,
                          output logic [1:0] resp, output int bfirst, output int held, output bit to);
    int cnt;
    to = 0; held = 0; bfirst = 0; resp = 2'bxx;
    awaddr = a; awburst = b; awlen = l; awvalid = 1'b1;
    cnt = 0;
    while (!awready && cnt < 50) begin tick(); cnt++; end
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = wbeats[i]; wstrb = wstrbs[i]; wlast = (i == last_at); wvalid = 1'b1;
      cnt = 0;
      while (!wready && cnt < 50) begin tick(); cnt++; end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    while (!bvalid && bfirst < 50) begin tick(); bfirst++; end
    if (!bvalid) begin to = 1; return; end
    resp = bresp;
    for (int k = 0; k < bdelay; k++) begin
      if (bvalid) held++;
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  // Issues one read burst, collecting beats into rd_*; bp inserts one rready-low cycle per beat.
  task automatic do_read(input logic [31:0] a, input logic [1:0] b, input logic [2:0] s,
                         input logic [7:0] l, input bit bp,
                         output int lat, output logic busy, output bit to);
    int cnt;
    logic [63:0] hold;
    to = 0; rd_unstable = 0; rd_gaps = 0;
    araddr = a; arburst = b; arsize = s; arlen = l; arvalid = 1'b1;
    cnt = 0;
    while (!arready && cnt < 50) begin tick(); cnt++; end
    tick();
    arvalid = 1'b0;
    busy = arready;
    lat = 1;
    while (!rvalid && lat < 50) begin tick(); lat++; end
    for (int i = 0; i <= int'(l); i++) begin
      cnt = 0;
      while (!rvalid && cnt < 50) begin tick(); cnt++; end
      if (i > 0) rd_gaps += cnt;
      if (!rvalid) begin to = 1; break; end
      if (bp) begin
        rready = 1'b0;
        hold = rdata;
        tick();
        if (!rvalid || rdata !== hold) rd_unstable++;
      end
      rready = 1'b1;
      rd_data[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast;
      tick();
      rready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_tests++; if (arready !== 1'b1 || awready !== 1'b1) begin n_fail++;
      $display("FAIL reset_ready: arready=%b awready=%b expected 1 1", arready, awready); end
    n_tests++; if (rvalid !== 1'b0 || rlast !== 1'b0 || rresp !== 2'b00 || rdata !== 64'h0) begin n_fail++;
      $display("FAIL reset_r: rvalid=%b rlast=%b rresp=%b rdata=%h expected all 0", rvalid, rlast, rresp, rdata); end
    n_tests++; if (wready !== 1'b0 || bvalid !== 1'b0 || bresp !== 2'b00) begin n_fail++;
      $display("FAIL reset_w: wready=%b bvalid=%b bresp=%b expected all 0", wready, bvalid, bresp); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    logic [1:0] resp; int bf, held, lat; bit to; logic busy;
    wbeats[0] = WV0; wstrbs[0] = 8'hFF;
    do_write(32'h8000_0000, 2'b01, 8'd0, 1, 0, 0, resp, bf, held, to);
    n_tests++; if (to || resp !== 2'b00) begin n_fail++;
      $display("FAIL single_preload_bresp: got %b timeout=%0d expected 00", resp, to); end
    do_read(32'h8000_0000, 2'b01, 3'd3, 8'd0, 1'b0, lat, busy, to);
    n_tests++; if (to || lat != 2) begin n_fail++;
      $display("FAIL single_latency: got %0d cycles timeout=%0d expected 2", lat, to); end
    n_tests++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL single_arready_busy: got %b expected 0", busy); end
    n_tests++; if (rd_data[0] !== WV0 || rd_resp[0] !== 2'b00 || rd_last[0] !== 1'b1) begin n_fail++;
      $display("FAIL single_beat: rdata=%h rresp=%b rlast=%b expected %h 00 1", rd_data[0], rd_resp[0], rd_last[0], WV0); end
    n_tests++; if (arready !== 1'b1 || rvalid !== 1'b0) begin n_fail++;
      $display("FAIL single_done: arready=%b rvalid=%b expected 1 0", arready, rvalid); end
  endtask

  task automatic test_incr_read();
    logic [1:0] resp; int bf, held, lat; bit to; logic busy;
    logic [63:0] exp [4];
    logic [3:0] lastm;
    exp[0] = WV1; exp[1] = WV2; exp[2] = WV3; exp[3] = WV4;
    for (int i = 0; i < 4; i++) begin wbeats[i] = exp[i]; wstrbs[i] = 8'hFF; end
    do_write(32'h8000_0008, 2'b01, 8'd3, 4, 3, 0, resp, bf, held, to);
    n_tests++; if (to || resp !== 2'b00) begin n_fail++;
      $display("FAIL incr_write_bresp: got %b timeout=%0d expected 00", resp, to); end
    do_read(32'h8000_0008, 2'b01, 3'd3, 8'd3, 1'b1, lat, busy, to);
    lastm = '0;
    for (int i = 0; i < 4; i++) begin
      lastm[i] = rd_last[i];
      n_tests++; if (to || rd_data[i] !== exp[i] || rd_resp[i] !== 2'b00) begin n_fail++;
        $display("FAIL incr_beat%0d: rdata=%h rresp=%b expected %h 00", i, rd_data[i], rd_resp[i], exp[i]); end
    end
    n_tests++; if (lastm !== 4'b1000) begin n_fail++;
      $display("FAIL incr_rlast: got %b expected 1000", lastm); end
    n_tests++; if (rd_unstable != 0) begin n_fail++;
      $display("FAIL incr_stable: %0d beats changed under backpressure, expected 0", rd_unstable); end
  endtask

  task automatic test_wrap_read();
    int lat; bit to; logic busy;
    logic [63:0] exp [4];
    logic [2:0] lastm;
    exp[0] = WV3; exp[1] = WV0; exp[2] = WV1; exp[3] = WV2;
    do_read(32'h8000_0018, 2'b10, 3'd3, 8'd3, 1'b0, lat, busy, to);
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (to || rd_data[i] !== exp[i] || rd_resp[i] !== 2'b00) begin n_fail++;
        $display("FAIL wrap_beat%0d: rdata=%h rresp=%b expected %h 00", i, rd_data[i], rd_resp[i], exp[i]); end
    end
    do_read(32'h8000_0018, 2'b10, 3'd3, 8'd2, 1'b0, lat, busy, to);
    lastm = '0;
    for (int i = 0; i < 3; i++) begin
      lastm[i] = rd_last[i];
      n_tests++; if (to || rd_data[i] !== 64'h0 || rd_resp[i] !== 2'b10) begin n_fail++;
        $display("FAIL wrap_bad_len_beat%0d: rdata=%h rresp=%b expected 0 10", i, rd_data[i], rd_resp[i]); end
    end
    n_tests++; if (lastm !== 3'b100) begin n_fail++;
      $display("FAIL wrap_bad_len_rlast: got %b expected 100", lastm); end
  endtask

  task automatic test_back_to_back();
    int lat; bit to; logic busy;
    logic [2:0] lastm;
    do_read(32'h8000_0008, 2'b00, 3'd3, 8'd2, 1'b0, lat, busy, to);
    lastm = '0;
    for (int i = 0; i < 3; i++) begin
      lastm[i] = rd_last[i];
      n_tests++; if (to || rd_data[i] !== WV1) begin n_fail++;
        $display("FAIL fixed_beat%0d: rdata=%h expected %h", i, rd_data[i], WV1); end
    end
    n_tests++; if (rd_gaps != 0 || lastm !== 3'b100) begin n_fail++;
      $display("FAIL b2b_gaps: gaps=%0d rlast=%b expected 0 100", rd_gaps, lastm); end
  endtask

  task automatic test_masked_write();
    logic [1:0] resp; int bf, held, lat; bit to; logic busy;
    wbeats[0] = 64'hAAAA_AAAA_AAAA_AAAA; wstrbs[0] = 8'hFF;
    do_write(32'h8000_0010, 2'b01, 8'd0, 1, 0, 0, resp, bf, held, to);
    wbeats[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstrbs[0] = 8'h0F;
    do_write(32'h8000_0010, 2'b01, 8'd0, 1, 0, 3, resp, bf, held, to);
    n_tests++; if (to || bf != 0 || resp !== 2'b00) begin n_fail++;
      $display("FAIL masked_bresp: bvalid after %0d cycles bresp=%b expected 0 00", bf, resp); end
    n_tests++; if (held != 3) begin n_fail++;
      $display("FAIL masked_bhold: bvalid held %0d cycles expected 3", held); end
    n_tests++; if (bvalid !== 1'b0 || awready !== 1'b1) begin n_fail++;
      $display("FAIL masked_bdone: bvalid=%b awready=%b expected 0 1", bvalid, awready); end
    do_read(32'h8000_0010, 2'b01, 3'd3, 8'd0, 1'b0, lat, busy, to);
    n_tests++; if (to || rd_data[0] !== 64'hAAAA_AAAA_FFFF_FFFF) begin n_fail++;
      $display("FAIL masked_data: got %h expected aaaaaaaaffffffff", rd_data[0]); end
  endtask

  task automatic test_errors();
    logic [1:0] resp; int bf, held, lat; bit to; logic busy;
    wbeats[0] = WTOP; wstrbs[0] = 8'hFF;
    do_write(32'h8000_7FF8, 2'b01, 8'd0, 1, 0, 0, resp, bf, held, to);
    wbeats[0] = 64'hBAD0_BAD0_BAD0_BAD0; wbeats[1] = 64'hBAD1_BAD1_BAD1_BAD1;
    wstrbs[0] = 8'hFF; wstrbs[1] = 8'hFF;
    do_write(32'h7FFF_FFF8, 2'b01, 8'd1, 2, 1, 0, resp, bf, held, to);
    n_tests++; if (to || resp !== 2'b10) begin n_fail++;
      $display("FAIL oor_write_bresp: got %b expected 10", resp); end
    do_read(32'h8000_7FF8, 2'b01, 3'd3, 8'd1, 1'b0, lat, busy, to);
    n_tests++; if (to || rd_data[0] !== WTOP || rd_resp[0] !== 2'b00) begin n_fail++;
      $display("FAIL top_beat0: rdata=%h rresp=%b expected %h 00", rd_data[0], rd_resp[0], WTOP); end
    n_tests++; if (to || rd_data[1] !== 64'h0 || rd_resp[1] !== 2'b10 || rd_last[1] !== 1'b1) begin n_fail++;
      $display("FAIL top_beat1: rdata=%h rresp=%b rlast=%b expected 0 10 1", rd_data[1], rd_resp[1], rd_last[1]); end
    do_read(32'h8000_0000, 2'b01, 3'd3, 8'd0, 1'b0, lat, busy, to);
    n_tests++; if (to || rd_data[0] !== WV0) begin n_fail++;
      $display("FAIL oor_write_dropped: word0=%h expected %h", rd_data[0], WV0); end
    do_read(32'h8000_8000, 2'b01, 3'd3, 8'd0, 1'b0, lat, busy, to);
    n_tests++; if (to || rd_data[0] !== 64'h0 || rd_resp[0] !== 2'b10) begin n_fail++;
      $display("FAIL oor_read: rdata=%h rresp=%b expected 0 10", rd_data[0], rd_resp[0]); end
    do_read(32'h8000_0000, 2'b11, 3'd3, 8'd0, 1'b0, lat, busy, to);
    n_tests++; if (to || rd_data[0] !== 64'h0 || rd_resp[0] !== 2'b10) begin n_fail++;
      $display("FAIL reserved_burst: rdata=%h rresp=%b expected 0 10", rd_data[0], rd_resp[0]); end
    wbeats[0] = 64'h5555_5555_5555_5555; wbeats[1] = 64'h6666_6666_6666_6666;
    do_write(32'h8000_0020, 2'b01, 8'd3, 2, 1, 0, resp, bf, held, to);
    n_tests++; if (to || resp !== 2'b10) begin n_fail++;
      $display("FAIL early_wlast_bresp: got %b expected 10", resp); end
    do_read(32'h8000_0020, 2'b01, 3'd3, 8'd0, 1'b0, lat, busy, to);
    n_tests++; if (to || rd_data[0] !== 64'h5555_5555_5555_5555) begin n_fail++;
      $display("FAIL early_wlast_data: got %h expected 5555555555555555", rd_data[0]); end
  endtask

  task automatic test_reset_mid_burst();
    int cnt, lat; bit to; logic busy;
    araddr = 32'h8000_0008; arburst = 2'b01; arsize = 3'd3; arlen = 8'd3; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    cnt = 0;
    while (!rvalid && cnt < 50) begin tick(); cnt++; end
    rready = 1'b1;
    tick(); tick();
    rready = 1'b0;
    n_tests++; if (rvalid !== 1'b1 || rdata !== WV3) begin n_fail++;
      $display("FAIL midburst_beat2: rvalid=%b rdata=%h expected 1 %h", rvalid, rdata, WV3); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (rvalid !== 1'b0 || arready !== 1'b1 || rlast !== 1'b0) begin n_fail++;
      $display("FAIL midburst_abort: rvalid=%b arready=%b rlast=%b expected 0 1 0", rvalid, arready, rlast); end
    do_read(32'h8000_0008, 2'b01, 3'd3, 8'd1, 1'b0, lat, busy, to);
    n_tests++; if (to || rd_data[0] !== WV1 || rd_data[1] !== 64'hAAAA_AAAA_FFFF_FFFF) begin n_fail++;
      $display("FAIL after_reset_data: got %h %h expected %h aaaaaaaaffffffff", rd_data[0], rd_data[1], WV1); end
  endtask

  initial begin
    rst = 1'b1;
    araddr = '0; arvalid = 1'b0; arburst = 2'b01; arlen = '0; arsize = 3'd3; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; awburst = 2'b01; awlen = '0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    test_reset();
    test_single_read();
    test_incr_read();
    test_wrap_read();
    test_back_to_back();
    test_masked_write();
    test_errors();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- Simulation/FPGA memory responder sitting on the slave side of the bus arbiter; answers instruction-fetch and load/store bursts from the CPU masters.
- Implements AR/R and AW/W/B channels with FIXED, INCR and WRAP bursts, a programmable read latency and an internal byte-maskable word array.
- Read and write channels run independent state machines.

Parameters:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 64, data bus width; wstrb is DATA_WIDTH/8.
- MEM_WORDS, 4096, depth of the internal array in DATA_WIDTH words.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- RD_LAT, 2, cycles from the AR handshake to the first rvalid; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- araddr  in  32  read burst start byte address
- arvalid  in  1  read address valid
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- arlen  in  8  beats minus 1
- arsize  in  3  bytes per beat = 2^arsize; legal values 0..3
- arready  out  1  read address accept
- rdata  out  64  read data
- rresp  out  2  00 OKAY, 10 SLVERR
- rvalid  out  1  read data valid
- rlast  out  1  final read beat
- rready  in  1  master accepts the read beat
- awaddr  in  32  write burst start byte address
- awvalid  in  1  write address valid
- awburst  in  2  write burst type; same encoding as arburst
- awlen  in  8  beats minus 1
- awready  out  1  write address accept
- wdata  in  64  write data
- wstrb  in  8  byte enables
- wlast  in  1  final write beat
- wvalid  in  1  write data valid
- wready  out  1  write data accept
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  master accepts the write response

Behaviour:
- Reset: all outputs are 0 except arready=1 and awready=1. Both FSMs return to IDLE. Array contents are retained.
- A reset asserted mid-burst aborts the burst. No further beats are issued and no response is sent.
- Word index = (addr - BASE_ADDR) >> 3.
- rdata is always the full addressed word. The master extracts the needed byte lanes.
- Next beat address by burst type:
  - FIXED: unchanged.
  - INCR: addr + 2^arsize.
  - WRAP: the low bits wrap within a container of (arlen+1)*2^arsize bytes. Legal WRAP arlen values are 1, 3, 7 and 15.
- Error conditions, all flagged at the AR or AW handshake:
  - burst type 11;
  - WRAP with an illegal arlen;
  - arsize > 3;
  - start address outside [BASE_ADDR, BASE_ADDR + 8*MEM_WORDS).
- On an error the whole burst still completes with the requested beat count:
  - reads return rresp=10 and rdata=0 on every beat;
  - writes are dropped and bresp=10.
- An INCR burst that crosses the top of memory is in range per beat. Beats past the top get SLVERR and rdata=0 or write dropped; earlier beats are OKAY.
- Read FSM:
  - R_IDLE: arready=1. On arvalid&arready, latch the burst, set beat count = arlen, set wait counter = RD_LAT-1, go to R_WAIT. If RD_LAT=1, go straight to R_DATA.
  - R_WAIT: decrement the counter each cycle; go to R_DATA when it reaches 0.
  - R_DATA: rvalid=1, and rlast=1 when the beat count is 0. rdata/rresp stay stable until rvalid&rready. On a handshake, advance the address; if it was the last beat, go to R_IDLE, else stay.
  - The first rvalid appears exactly RD_LAT cycles after the AR handshake cycle. Back-to-back beats are possible with rready held high.
- Write FSM:
  - W_IDLE: awready=1. On the AW handshake go to W_DATA.
  - W_DATA: wready=1. On each wvalid&wready, write the bytes whose wstrb bit is set, then advance the address.
  - The burst ends on the beat with wlast=1. bresp=10 if wlast arrives on a beat other than beat awlen. Beats past awlen without wlast are dropped and flag SLVERR.
  - W_RESP: bvalid=1 from the cycle after the last W handshake, held until bready. Then go to W_IDLE.
- A write beat and a read beat to the same word in the same cycle: the read returns the old data. The written value is visible from the next cycle.
- arready is 0 outside R_IDLE and awready is 0 outside W_IDLE, so there is only one outstanding burst per direction.

Test Plan:
- Single read: preload word 0 = 64'h1122334455667788; araddr=80000000, arlen=0, arburst=01, RD_LAT=2 → rvalid in cycle T+2, rdata=1122334455667788, rresp=00, rlast=1, arready back to 1 the cycle after the handshake.
- INCR read, 4 beats with backpressure: araddr=80000008, arsize=3, arlen=3, rready toggled every other cycle → words 1,2,3,4 in order; rdata held stable while rready=0; rlast only on beat 4.
- WRAP read: araddr=80000018, arsize=3, arlen=3 → word order 3,0,1,2; arlen=2 with WRAP → 3 beats, all rresp=10, rdata=0.
- Masked write: awaddr=80000010, awlen=0, wdata=FFFF_FFFF_FFFF_FFFF, wstrb=8'h0F, old word AAAAAAAA_AAAAAAAA → word becomes AAAAAAAA_FFFFFFFF; bvalid the cycle after the W handshake, bresp=00, held 3 cycles until bready.
- Errors: awaddr=7FFFFFF8 with a 2-beat write → memory unchanged, bresp=10; early wlast on beat 1 of an awlen=3 burst → bresp=10, and the first beat is still written.
- Reset mid-burst: assert rst during beat 2 of a 4-beat read → next cycle rvalid=0, arready=1; a new read then returns correct data, and previously written memory is intact.
